// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 16-bit log shifter. Contention is
// resolved round-robin, and the result is held in a one-entry output register
// until the consumer takes it.
module shift_arbiter #(
  parameter logic RESET_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_in,
  input  logic [3:0]  req0_cnt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_in,
  input  logic [3:0]  req1_cnt,
  input  logic [1:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id
);

  // Op encoding
  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  // One stage of the log shifter. Every call passes a constant amount, so each
  // stage reduces to a fixed-wiring direction/fill mux.
  function automatic logic [15:0] f_stage(
    input logic [15:0] x,
    input logic        en,
    input logic [1:0]  op,
    input logic [4:0]  s
  );
    logic [15:0] y;
    y = x;
    if (en) begin
      case (op)
        OP_ROL:  y = (x << s) | (x >> (5'd16 - s));
        OP_SLL:  y = x << s;
        OP_SRA:  y = $signed(x) >>> s;
        OP_SRL:  y = x >> s;
        default: y = x;
      endcase
    end else begin
      y = x;
    end
    return y;
  endfunction

  // State: output register and priority pointer
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_id;
  logic        r_pri;

  // Combinational signals
  logic        w_slot_free;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic [15:0] w_sel_in;
  logic [3:0]  w_sel_cnt;
  logic [1:0]  w_sel_op;
  logic [15:0] w_st8;
  logic [15:0] w_st4;
  logic [15:0] w_st2;
  logic [15:0] w_st1;
  logic        w_nxt_valid;
  logic [15:0] w_nxt_data;
  logic        w_nxt_id;
  logic        w_nxt_pri;

  // Grant: lone requester wins, contention goes to pri, nothing while the slot is busy or in reset
  always_comb begin
    w_slot_free = ~r_rsp_valid | rsp_ready;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    if (rst) begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end else if (w_slot_free) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = ~r_pri;
        w_grant1 = r_pri;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
  end

  assign w_accept   = w_grant0 | w_grant1;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Operand mux feeding the single shared shifter
  always_comb begin
    w_sel_in  = req0_in;
    w_sel_cnt = req0_cnt;
    w_sel_op  = req0_op;
    if (w_grant1) begin
      w_sel_in  = req1_in;
      w_sel_cnt = req1_cnt;
      w_sel_op  = req1_op;
    end else begin
      w_sel_in  = req0_in;
      w_sel_cnt = req0_cnt;
      w_sel_op  = req0_op;
    end
  end

  // Log shifter stages 8/4/2/1; SRA stays correct across stages because bit 15 is never replaced
  assign w_st8 = f_stage(w_sel_in, w_sel_cnt[3], w_sel_op, 5'd8);
  assign w_st4 = f_stage(w_st8,    w_sel_cnt[2], w_sel_op, 5'd4);
  assign w_st2 = f_stage(w_st4,    w_sel_cnt[1], w_sel_op, 5'd2);
  assign w_st1 = f_stage(w_st2,    w_sel_cnt[0], w_sel_op, 5'd1);

  // Next-state for output register and pointer: accept loads/overwrites, drain clears valid, otherwise hold
  always_comb begin
    w_nxt_valid = r_rsp_valid;
    w_nxt_data  = r_rsp_data;
    w_nxt_id    = r_rsp_id;
    w_nxt_pri   = r_pri;
    if (w_accept) begin
      w_nxt_valid = 1'b1;
      w_nxt_data  = w_st1;
      w_nxt_id    = w_grant1;
      w_nxt_pri   = w_grant0;  // priority moves to the requester not served
    end else if (r_rsp_valid && rsp_ready) begin
      w_nxt_valid = 1'b0;
    end else begin
      w_nxt_valid = r_rsp_valid;
    end
  end

  // State registers with synchronous reset; a pending result is discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_id    <= 1'b0;
      r_pri       <= RESET_PRI;
    end else begin
      r_rsp_valid <= w_nxt_valid;
      r_rsp_data  <= w_nxt_data;
      r_rsp_id    <= w_nxt_id;
      r_pri       <= w_nxt_pri;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 16-bit barrel shifter datapath between two requesters, e.g. the execute-stage ALU path and a multi-cycle helper unit.
- Grants requests round-robin and computes the shift or rotate for the granted request.
- Holds the result in a one-entry output register until the consumer accepts it.
- Sits beside the execute stage and replaces per-requester shifter copies.

Parameters:
- RESET_PRI, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_in  input  16  requester 0 operand.
- req0_cnt  input  4  requester 0 shift amount, 0..15.
- req0_op  input  2  requester 0 operation.
- req1_valid, req1_ready, req1_in, req1_cnt, req1_op: same as requester 0, for requester 1.
- rsp_valid  output  1  output register holds a result.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_data  output  16  shifted result.
- rsp_id  output  1  requester that owns rsp_data.

Behaviour:
- Op encoding:
  - 00 = ROL, rotate left by cnt.
  - 01 = SLL, zero-fill.
  - 10 = SRA, sign-fill from bit 15.
  - 11 = SRL, zero-fill.
  - cnt = 0 passes the operand unchanged for all ops.
- Datapath: a single log shifter with stages 8/4/2/1 selected by cnt[3..0], plus a direction/fill mux. Exactly one instance; no per-requester copies.
- Slot free: slot_free = !rsp_valid | rsp_ready.
- Grant, combinational:
  - Only one requester valid and slot_free: grant it.
  - Both valid and slot_free: grant the requester named by pri.
  - slot_free = 0: no grant.
- Ready: reqN_ready = grant to N. At most one ready per cycle. Ready never depends on the same requester's ready.
- Accept (reqN_valid & reqN_ready) at edge N:
  - Load rsp_data with the shifter result, rsp_id with N, rsp_valid with 1.
  - Latency is 1 cycle: result visible in cycle N+1.
- Drain: rsp_valid & rsp_ready with no accept clears rsp_valid. A simultaneous accept overwrites the register, which sustains 1 result/cycle.
- Hold: rsp_valid & !rsp_ready keeps rsp_data, rsp_id and rsp_valid stable, and all reqN_ready stay low.
- Priority pointer pri:
  - After any accept, pri <= the non-granted requester.
  - With no accept, pri is unchanged.
  - A lone requester is granted back-to-back; round-robin only arbitrates contention.
- Requesters must hold valid and payload until ready; the block does not register unaccepted requests.
- Reset (rst = 1 at edge), any time including mid-hold:
  - rsp_valid <= 0, rsp_data <= 0, rsp_id <= 0, pri <= RESET_PRI.
  - Any pending result is discarded.
  - reqN_ready is forced 0 while rst is high.
- Outputs after reset: rsp_valid = 0, rsp_data = 16'h0000, rsp_id = 0, req0_ready = req1_ready = 0 until the first cycle with rst low.
- No state beyond: one output register (16 + 1 + 1 bits) and the pri flop.

Test Plan:
- Per-op check, req0 only, rsp_ready = 1:
  - in = 16'h8001, op = 00, cnt = 1 -> rsp_data = 16'h0003, rsp_id = 0, one cycle after accept.
  - in = 16'h1234, op = 01, cnt = 4 -> 16'h2340.
  - in = 16'h8000, op = 10, cnt = 4 -> 16'hF800.
  - in = 16'h8000, op = 11, cnt = 15 -> 16'h0001.
  - cnt = 0, any op, in = 16'hA5A5 -> 16'hA5A5.
- Contention: both valid continuously for 6 cycles, RESET_PRI = 0, rsp_ready = 1 -> grant order 0,1,0,1,0,1; one rsp per cycle; rsp_id alternates.
- Backpressure:
  - rsp_ready = 0 for 3 cycles after the first result -> rsp_data/rsp_id stable, both readys low.
  - Raise rsp_ready -> a new accept occurs the same cycle; the next result appears the following cycle.
- Lone requester streaming: req1 valid for 4 cycles, req0 idle -> req1_ready high each cycle; 4 results with rsp_id = 1; pri ends at 0.
- Reset mid-hold: rsp_valid = 1, rsp_ready = 0, assert rst one cycle -> next cycle rsp_valid = 0, rsp_data = 0. With both valid, the first grant goes to RESET_PRI.
- Randomized soak, 2000 cycles, random valid/ready/payloads -> every rsp matches the reference shift. No lost or duplicated requests. No requester waits more than 2 grants while continuously valid.
